// File: rtl/dbus_arbiter.sv
// Three-way arbiter/sequencer for the shared data bus: CPU, FFT and crypto masters
// share one single-word memory port, with wait counters preventing accelerator starvation.
module dbus_arbiter #(
  parameter int AW       = 19,
  parameter int DW       = 19,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req_i,
  input  logic          cpu_write_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_done_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          fft_req_i,
  input  logic          fft_write_i,
  input  logic [AW-1:0] fft_addr_i,
  input  logic [DW-1:0] fft_wdata_i,
  output logic          fft_gnt_o,
  output logic          fft_done_o,
  output logic [DW-1:0] fft_rdata_o,
  input  logic          cry_req_i,
  input  logic          cry_write_i,
  input  logic [AW-1:0] cry_addr_i,
  input  logic [DW-1:0] cry_wdata_i,
  output logic          cry_gnt_o,
  output logic          cry_done_o,
  output logic [DW-1:0] cry_rdata_o,
  output logic          mem_valid_o,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {OWN_CPU = 2'd0, OWN_FFT = 2'd1, OWN_CRY = 2'd2} owner_e;

  localparam logic [3:0] MaxW = 4'(MAX_WAIT);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d, win;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_write_q, mem_write_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [2:0]           gnt_q, gnt_d;
  logic [2:0]           done_q, done_d;
  logic [2:0][DW-1:0]   rdata_q, rdata_d;
  logic [3:0]           fft_cnt_q, fft_cnt_d, cry_cnt_q, cry_cnt_d;
  logic                 rr_cry_q, rr_cry_d;  // 0: fft has round-robin preference, 1: cry
  logic                 fft_hot, cry_hot, any_req;

  assign fft_hot = fft_req_i && (fft_cnt_q == MaxW);
  assign cry_hot = cry_req_i && (cry_cnt_q == MaxW);
  assign any_req = cpu_req_i || fft_req_i || cry_req_i;

  // Starved accelerators outrank the CPU; the CPU outranks ordinary accelerator traffic.
  always_comb begin
    win = OWN_CPU;
    if (fft_hot && cry_hot)          win = rr_cry_q ? OWN_CRY : OWN_FFT;
    else if (fft_hot)                win = OWN_FFT;
    else if (cry_hot)                win = OWN_CRY;
    else if (cpu_req_i)              win = OWN_CPU;
    else if (fft_req_i && cry_req_i) win = rr_cry_q ? OWN_CRY : OWN_FFT;
    else if (fft_req_i)              win = OWN_FFT;
    else if (cry_req_i)              win = OWN_CRY;
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = '0;
    done_d      = '0;
    rdata_d     = rdata_q;
    fft_cnt_d   = fft_cnt_q;
    cry_cnt_d   = cry_cnt_q;
    rr_cry_d    = rr_cry_q;
    unique case (state_q)
      IDLE: if (any_req) begin
        state_d     = BUSY;
        owner_d     = win;
        mem_valid_d = 1'b1;
        gnt_d[win]  = 1'b1;
        unique case (win)
          OWN_FFT: begin
            mem_write_d = fft_write_i;
            mem_addr_d  = fft_addr_i;
            mem_wdata_d = fft_wdata_i;
          end
          OWN_CRY: begin
            mem_write_d = cry_write_i;
            mem_addr_d  = cry_addr_i;
            mem_wdata_d = cry_wdata_i;
          end
          default: begin
            mem_write_d = cpu_write_i;
            mem_addr_d  = cpu_addr_i;
            mem_wdata_d = cpu_wdata_i;
          end
        endcase
        if (win == OWN_FFT)                     fft_cnt_d = '0;
        else if (fft_req_i && fft_cnt_q < MaxW) fft_cnt_d = fft_cnt_q + 4'd1;
        if (win == OWN_CRY)                     cry_cnt_d = '0;
        else if (cry_req_i && cry_cnt_q < MaxW) cry_cnt_d = cry_cnt_q + 4'd1;
        if (win != OWN_CPU) rr_cry_d = ~rr_cry_q;
      end
      BUSY: if (mem_ready_i) begin
        state_d         = IDLE;
        mem_valid_d     = 1'b0;
        done_d[owner_q] = 1'b1;
        if (!mem_write_q) rdata_d[owner_q] = mem_rdata_i;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      fft_cnt_q   <= '0;
      cry_cnt_q   <= '0;
      rr_cry_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      fft_cnt_q   <= fft_cnt_d;
      cry_cnt_q   <= cry_cnt_d;
      rr_cry_q    <= rr_cry_d;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_gnt_o   = gnt_q[OWN_CPU];
  assign fft_gnt_o   = gnt_q[OWN_FFT];
  assign cry_gnt_o   = gnt_q[OWN_CRY];
  assign cpu_done_o  = done_q[OWN_CPU];
  assign fft_done_o  = done_q[OWN_FFT];
  assign cry_done_o  = done_q[OWN_CRY];
  assign cpu_rdata_o = rdata_q[OWN_CPU];
  assign fft_rdata_o = rdata_q[OWN_FFT];
  assign cry_rdata_o = rdata_q[OWN_CRY];

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: single transactions, wait states, starvation
// override sequence, accelerator alternation and mid-transaction reset.
module tb_dbus_arbiter;

  localparam int AW = 19;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, fft_req, cry_req;
  logic          cpu_write, fft_write, cry_write;
  logic [AW-1:0] cpu_addr, fft_addr, cry_addr;
  logic [DW-1:0] cpu_wdata, fft_wdata, cry_wdata;
  logic          cpu_gnt, fft_gnt, cry_gnt;
  logic          cpu_done, fft_done, cry_done;
  logic [DW-1:0] cpu_rdata, fft_rdata, cry_rdata;
  logic          mem_valid, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dbus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_write_i(cpu_write), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_done_o(cpu_done), .cpu_rdata_o(cpu_rdata),
    .fft_req_i(fft_req), .fft_write_i(fft_write), .fft_addr_i(fft_addr), .fft_wdata_i(fft_wdata),
    .fft_gnt_o(fft_gnt), .fft_done_o(fft_done), .fft_rdata_o(fft_rdata),
    .cry_req_i(cry_req), .cry_write_i(cry_write), .cry_addr_i(cry_addr), .cry_wdata_i(cry_wdata),
    .cry_gnt_o(cry_gnt), .cry_done_o(cry_done), .cry_rdata_o(cry_rdata),
    .mem_valid_o(mem_valid), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; fft_req = 0; cry_req = 0;
    cpu_write = 0; fft_write = 0; cry_write = 0;
    cpu_addr = '0; fft_addr = '0; cry_addr = '0;
    cpu_wdata = '0; fft_wdata = '0; cry_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Waits (bounded) for the next grant and returns {cry,fft,cpu} grant bits.
  task automatic next_gnt(output logic [2:0] g);
    g = 3'b000;
    for (int i = 0; i < 6 && g == 3'b000; i++) begin
      @(negedge clk);
      g = {cry_gnt, fft_gnt, cpu_gnt};
    end
  endtask

  logic [2:0] g;
  logic [2:0] exp_seq [19];
  int         busy_done;

  initial begin
    do_reset();
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_gnt_done", 32'({cpu_gnt, fft_gnt, cry_gnt, cpu_done, fft_done, cry_done}), 0);
    check("rst_rdata", 32'(cpu_rdata | fft_rdata | cry_rdata), 0);

    // Lone CPU read, immediate ready.
    cpu_req = 1; cpu_addr = 19'h00123; mem_ready = 1; mem_rdata = 19'h7ABCD;
    @(negedge clk);
    check("t1_gnt", 32'(cpu_gnt), 1);
    check("t1_valid", 32'(mem_valid), 1);
    check("t1_addr", 32'(mem_addr), 32'h00123);
    check("t1_write", 32'(mem_write), 0);
    cpu_req = 0;
    @(negedge clk);
    check("t1_done", 32'(cpu_done), 1);
    check("t1_rdata", 32'(cpu_rdata), 32'h7ABCD);
    check("t1_valid_off", 32'(mem_valid), 0);

    // FFT write with three wait states.
    mem_ready = 0; mem_rdata = 19'h00F0F;
    fft_req = 1; fft_write = 1; fft_addr = 19'h40000; fft_wdata = 19'h15555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t2_gnt", 32'(fft_gnt), 1);
        fft_req = 0; fft_addr = '0; fft_wdata = '0;
      end
      check("t2_valid", 32'(mem_valid), 1);
      check("t2_fields", 32'({mem_write, mem_addr}), 32'({1'b1, 19'h40000}));
      check("t2_wdata", 32'(mem_wdata), 32'h15555);
      check("t2_no_done", 32'(fft_done), 0);
      if (i == 3) mem_ready = 1;
    end
    @(negedge clk);
    mem_ready = 0;
    check("t2_done", 32'(fft_done), 1);
    check("t2_valid_off", 32'(mem_valid), 0);
    check("t2_fft_rdata", 32'(fft_rdata), 0);
    check("t2_cpu_rdata_held", 32'(cpu_rdata), 32'h7ABCD);

    // All three requesting continuously: starvation override sequence.
    do_reset();
    for (int i = 0; i < 8; i++) exp_seq[i] = 3'b001;
    exp_seq[8] = 3'b010; exp_seq[9] = 3'b100;
    for (int i = 10; i < 17; i++) exp_seq[i] = 3'b001;
    exp_seq[17] = 3'b010; exp_seq[18] = 3'b100;
    cpu_req = 1; fft_req = 1; cry_req = 1; mem_ready = 1;
    for (int i = 0; i < 19; i++) begin
      next_gnt(g);
      check($sformatf("t3_round%0d", i), 32'(g), 32'(exp_seq[i]));
    end
    cpu_req = 0; fft_req = 0; cry_req = 0;
    @(negedge clk);

    // CPU idle, both accelerators requesting: strict alternation from fft.
    do_reset();
    fft_req = 1; cry_req = 1; mem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      next_gnt(g);
      check($sformatf("t4_round%0d", i), 32'(g), (i % 2 == 0) ? 32'b010 : 32'b100);
    end
    fft_req = 0; cry_req = 0;
    @(negedge clk);

    // Reset while BUSY with memory stalled.
    do_reset();
    cpu_req = 1; cpu_write = 1; cpu_addr = 19'h0ABCD; mem_ready = 0;
    @(negedge clk);
    check("t5_busy", 32'(mem_valid), 1);
    rst_n = 0;
    #1;
    check("t5_valid_drop", 32'(mem_valid), 0);
    check("t5_addr_clear", 32'(mem_addr), 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    mem_ready = 1;
    busy_done = 0;
    repeat (3) begin
      @(negedge clk);
      busy_done = busy_done | int'(cpu_done) | int'(mem_valid);
    end
    check("t5_no_done", 32'(busy_done), 0);
    fft_req = 1; cry_req = 1;
    next_gnt(g);
    check("t5_restart_fft", 32'(g), 32'b010);
    fft_req = 0; cry_req = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
